half_predict_sequencer: RTL

- Top-level controller for the two-layer half-precision inference pipeline.
- Sequences the layer-1 and layer-2 predict blocks through their start/done handshakes, then snapshots the softmax output vector.
- Performs a sequential argmax over that vector and reports the winning class.
- Provides a per-stage watchdog and an abort input; sits between the host/testbench and the predict layers.

---
 rtl/half_predict_sequencer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/half_predict_sequencer.sv
// half_predict_sequencer: sequences layer-1/layer-2 predict blocks, then argmaxes the half-precision softmax outputs
// Ports: clk/rst (async, active-high); start/abort host controls; busy status;
//   l1_start/l1_done and l2_start/l2_done layer handshakes; y packed layer-2 outputs (element k at y[16*k +: 16]);
//   done pulse with class_idx/class_val result; error sticky watchdog flag.
module half_predict_sequencer #(
  parameter int OUTPUT_NODES = 10,
  parameter int IDX_W = 4,
  parameter int TIMEOUT = 4096,
  parameter int TMO_W = 13
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic l1_start,
  input  logic l1_done,
  output logic l2_start,
  input  logic l2_done,
  input  logic [16*OUTPUT_NODES-1:0] y,
  output logic done,
  output logic [IDX_W-1:0] class_idx,
  output logic [15:0] class_val,
  output logic error
);
  typedef enum logic [2:0] {IDLE, RUN_L1, WAIT_L1, RUN_L2, WAIT_L2, SCAN, FIN} state_t;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(OUTPUT_NODES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  state_t state, nxt;
  logic tmo, accept;
  logic [TMO_W-1:0] cnt;
  logic [IDX_W-1:0] i, best_idx, res_idx;
  logic [15:0] best_val, res_val;
  logic [15:0] snap [OUTPUT_NODES];
  // NaN loses to everything, -0 folds onto +0, negatives order by inverted raw bits
  function automatic logic gt(input logic [15:0] a, input logic [15:0] b);
    logic na, nb;
    logic [15:0] ca, cb;
    na = (&a[14:10]) && (|a[9:0]);
    nb = (&b[14:10]) && (|b[9:0]);
    ca = (a == 16'h8000) ? 16'h0000 : a;
    cb = (b == 16'h8000) ? 16'h0000 : b;
    return na ? 1'b0 : nb ? 1'b1 : (ca[15] != cb[15]) ? cb[15] : ca[15] ? (ca < cb) : (ca > cb);
  endfunction
  assign busy = state != IDLE;
  assign accept = (state == IDLE) && start && !abort;
  // the result becomes visible in the done cycle and is held afterwards
  assign class_idx = done ? best_idx : res_idx;
  assign class_val = done ? best_val : res_val;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    l1_start = 1'b0;
    l2_start = 1'b0;
    done = 1'b0;
    tmo = 1'b0;
    case (state)
      IDLE: nxt = accept ? RUN_L1 : IDLE;
      RUN_L1: begin
        l1_start = 1'b1;
        nxt = WAIT_L1;
      end
      WAIT_L1: begin
        tmo = !l1_done && (cnt == TMO_LAST);
        nxt = l1_done ? RUN_L2 : tmo ? IDLE : WAIT_L1;
      end
      RUN_L2: begin
        l2_start = 1'b1;
        nxt = WAIT_L2;
      end
      WAIT_L2: begin
        tmo = !l2_done && (cnt == TMO_LAST);
        nxt = l2_done ? ((OUTPUT_NODES == 1) ? FIN : SCAN) : tmo ? IDLE : WAIT_L2;
      end
      SCAN: nxt = (i == LAST) ? FIN : SCAN;
      FIN: begin
        done = 1'b1;
        nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
    if (abort && state != IDLE) begin
      nxt = IDLE;
      l1_start = 1'b0;
      l2_start = 1'b0;
      done = 1'b0;
      tmo = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      i <= '0;
      best_idx <= '0;
      best_val <= '0;
      res_idx <= '0;
      res_val <= '0;
      error <= 1'b0;
      for (int k = 0; k < OUTPUT_NODES; k++) snap[k] <= '0;
    end else begin
      cnt <= (state == WAIT_L1 || state == WAIT_L2) ? cnt + TMO_W'(1) : '0;
      if (accept) begin
        error <= 1'b0;
        res_idx <= '0;
        res_val <= '0;
      end
      if (tmo) error <= 1'b1;
      if (state == WAIT_L2 && l2_done && !abort) begin
        for (int k = 0; k < OUTPUT_NODES; k++) snap[k] <= y[16*k +: 16];
        best_val <= y[15:0];
        best_idx <= '0;
        i <= IDX_W'(1);
      end
      if (state == SCAN && !abort) begin
        if (gt(snap[i], best_val)) begin
          best_val <= snap[i];
          best_idx <= i;
        end
        i <= i + IDX_W'(1);
      end
      if (done) begin
        res_idx <= best_idx;
        res_val <= best_val;
      end
    end
endmodule
